// File: rtl/byte_serial_wide_adder.sv
// byte_serial_wide_adder: N-byte add over a byte stream, carry chained per beat.
// Ports: in_* beat + valid/ready, out_* registered result beat, busy, err_sticky.
module byte_serial_wide_adder #(
  parameter int NBYTES = 4,
  parameter int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_a,
  input  logic [7:0]      in_b,
  input  logic            in_cin,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_sum,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_cout,
  output logic            out_err,
  output logic            busy,
  output logic            err_sticky
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDXW-1:0] r_cnt;
  logic            r_carry;
  logic            r_out_valid;
  logic [7:0]      r_out_sum;
  logic [IDXW-1:0] r_out_idx;
  logic            r_out_last;
  logic            r_out_cout;
  logic            r_out_err;
  logic            r_err_sticky;

  logic            w_accept;
  logic            w_is_last;
  logic            w_cy;
  logic            w_err;
  logic [8:0]      w_res;

  // single output register: refill allowed whenever it drains this cycle
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_is_last = (r_cnt == LAST_IDX);
  // beat 0 always takes the word carry-in, so no carry crosses words
  assign w_cy      = (r_cnt == '0) ? in_cin : r_carry;
  assign w_res     = {1'b0, in_a} + {1'b0, in_b} + {8'b0, w_cy};
  assign w_err     = (in_last != w_is_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
      r_out_cout   <= 1'b0;
      r_out_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else if (w_accept) begin
      r_cnt        <= w_is_last ? '0 : r_cnt + 1'b1;
      r_carry      <= w_res[8];
      r_out_valid  <= 1'b1;
      r_out_sum    <= w_res[7:0];
      r_out_idx    <= r_cnt;
      r_out_last   <= w_is_last;
      r_out_cout   <= w_is_last & w_res[8];
      r_out_err    <= w_err;
      r_err_sticky <= r_err_sticky | w_err;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && (NBYTES > 1)) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (w_accept && w_is_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_ACCUM);
  end

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;
  assign out_cout   = r_out_cout;
  assign out_err    = r_out_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_byte_serial_wide_adder.sv
// tb_byte_serial_wide_adder: vector table, corner sequences, random vs word model.
// Drives at posedge+1, samples at negedge.
module tb_byte_serial_wide_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [1:0] out_idx;
  logic       out_last;
  logic       out_cout;
  logic       out_err;
  logic       busy;
  logic       err_sticky;

  byte_serial_wide_adder #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx),
    .out_last(out_last), .out_cout(out_cout),
    .out_err(out_err), .busy(busy),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sum;
    logic [1:0] idx;
    logic       last;
    logic       cout;
    logic       err;
  } beat_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [3:0]  lastm;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic [3:0]  exp_err;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    mon_en = 1'b1;
  bit    bp_on = 1'b0;
  bit    exp_sticky = 1'b0;
  beat_t q_got[$];
  int    q_cyc[$];
  beat_t q_exp[$];
  vec_t  tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      q_got.push_back({out_sum, out_idx, out_last, out_cout, out_err});
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic void push_raw(input logic [31:0] s, input logic c,
                                   input logic [3:0] e);
    beat_t x;
    for (int i = 0; i < 4; i++) begin
      x.sum  = s[8*i +: 8];
      x.idx  = 2'(i);
      x.last = (i == 3);
      x.cout = (i == 3) ? c : 1'b0;
      x.err  = e[i];
      q_exp.push_back(x);
    end
  endfunction

  // word-level reference: plain 33-bit addition and expected marker pattern
  function automatic void model_push(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic [3:0] lm);
    logic [32:0] full;
    logic [3:0]  e;
    full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    e    = lm ^ 4'b1000;
    if (e != 4'b0) exp_sticky = 1'b1;
    push_raw(full[31:0], full[32], e);
  endfunction

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic last);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = cin; in_last = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [3:0] lm,
                           input bit rnd);
    for (int i = 0; i < 4; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(a[8*i +: 8], b[8*i +: 8],
                (i == 0) ? cin : 1'($urandom_range(0, 1)), lm[i]);
    end
  endtask

  task automatic drain(input bit contig);
    beat_t g, e;
    int    n, gc, prevc;
    bit    ok, first;
    ok = 1'b1;
    first = 1'b1;
    prevc = 0;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n = 0;
      while (q_got.size() == 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (q_got.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=missing required=%h", e);
        q_exp.delete();
        break;
      end
      g  = q_got.pop_front();
      gc = q_cyc.pop_front();
      chk("beat", 32'(g), 32'(e));
      if (!first && gc != prevc + 1) ok = 1'b0;
      prevc = gc;
      first = 1'b0;
    end
    if (contig) chk("contiguous", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    chk("no_extra", q_got.size(), 32'd0);
    q_got.delete();
    q_cyc.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_cout", 32'(out_cout), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 4'b1000,
               32'h00000100, 1'b0, 4'b0000};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b1000,
               32'h00000000, 1'b1, 4'b0000};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 4'b1000,
               32'h00000000, 1'b1, 4'b0000};
    tbl[3] = '{32'h00000000, 32'h00000000, 1'b0, 4'b1000,
               32'h00000000, 1'b0, 4'b0000};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 4'b1000,
               32'h00000001, 1'b1, 4'b0000};
    tbl[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 4'b1000,
               32'hACF13568, 1'b0, 4'b0000};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state();

    // table: all words back to back, one beat per cycle
    for (int i = 0; i < 6; i++) begin
      push_raw(tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].exp_err);
      send_word(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].lastm, 1'b0);
    end
    drain(1'b1);
    chk("sticky_clean", 32'(err_sticky), 0);

    // in_last on beat 1, missing on beat 3
    model_push(32'h11111111, 32'h22222222, 1'b0, 4'b0010);
    send_word(32'h11111111, 32'h22222222, 1'b0, 4'b0010, 1'b0);
    drain(1'b0);
    chk("sticky_set", 32'(err_sticky), 1);

    // reset after two beats, one of them still held in the output reg
    mon_en = 1'b0;
    send_beat(8'hAA, 8'h55, 1'b1, 1'b0);
    send_beat(8'hAA, 8'h55, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sticky = 1'b0;
    chk_reset_state();
    mon_en = 1'b1;
    model_push(32'h00000001, 32'h00000001, 1'b1, 4'b1000);
    send_word(32'h00000001, 32'h00000001, 1'b1, 4'b1000, 1'b0);
    drain(1'b0);

    // backpressure for 3 cycles with beat 1 in the output register
    model_push(32'h01020304, 32'h10203040, 1'b0, 4'b1000);
    send_beat(8'h04, 8'h40, 1'b0, 1'b0);
    send_beat(8'h03, 8'h30, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h02; in_b = 8'h20; in_cin = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_sum", 32'(out_sum), 32'h33);
      chk("bp_out_idx", 32'(out_idx), 1);
      chk("bp_busy", 32'(busy), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(8'h02, 8'h20, 1'b1, 1'b0);
    send_beat(8'h01, 8'h10, 1'b0, 1'b1);
    drain(1'b0);

    // random words, random gaps and random downstream stalls
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          if (bp_on) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int w = 0; w < 40; w++) begin
      logic [31:0] a, b;
      logic        c;
      logic [3:0]  lm;
      a  = $urandom;
      b  = $urandom;
      c  = 1'($urandom_range(0, 1));
      lm = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b1000;
      model_push(a, b, c, lm);
      send_word(a, b, c, lm, 1'b1);
    end
    bp_on = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain(1'b0);
    chk("rand_sticky", 32'(err_sticky), 32'(exp_sticky));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
